// File: rtl/dram_arbiter_if.sv
// Bus bundle between the EXE/MEM load/store path, the DMA/debug port and the data RAM macro.
// The arbiter connects through the slave modport; the surrounding pipeline/RAM side uses master.
interface dram_arbiter_if;
  logic        cpu_req;
  logic [31:0] cpu_addr;
  logic [31:0] cpu_wdata;
  logic [3:0]  cpu_wen;
  logic        cpu_grant;
  logic        cpu_rvalid;
  logic [31:0] cpu_rdata;

  logic        dma_req;
  logic [31:0] dma_addr;
  logic [31:0] dma_wdata;
  logic [3:0]  dma_wen;
  logic        dma_grant;
  logic        dma_rvalid;
  logic [31:0] dma_rdata;

  logic        ram_en;
  logic [31:0] ram_addr;
  logic [31:0] ram_wdata;
  logic [3:0]  ram_wen;
  logic [31:0] ram_rdata;

  modport slave (
    input  cpu_req, cpu_addr, cpu_wdata, cpu_wen,
    input  dma_req, dma_addr, dma_wdata, dma_wen,
    input  ram_rdata,
    output cpu_grant, cpu_rvalid, cpu_rdata,
    output dma_grant, dma_rvalid, dma_rdata,
    output ram_en, ram_addr, ram_wdata, ram_wen
  );

  modport master (
    output cpu_req, cpu_addr, cpu_wdata, cpu_wen,
    output dma_req, dma_addr, dma_wdata, dma_wen,
    output ram_rdata,
    input  cpu_grant, cpu_rvalid, cpu_rdata,
    input  dma_grant, dma_rvalid, dma_rdata,
    input  ram_en, ram_addr, ram_wdata, ram_wen
  );
endinterface

// File: rtl/dram_arbiter.sv
// Data RAM arbiter: CPU priority with a starvation-forced DMA slot after STARVE_LIMIT denials.
// Optional macro DRAM_ARB_PERF_EN adds conflict / CPU-stall performance counters.
module dram_arbiter #(
  parameter int STARVE_LIMIT = 4
) (
  input  logic               clk,
  input  logic               resetn,
  dram_arbiter_if.slave      bus
`ifdef DRAM_ARB_PERF_EN
  ,
  output logic [31:0]        perf_conflict_cnt,
  output logic [31:0]        perf_cpu_stall_cnt
`endif
);

  localparam logic [0:0] ARB_CPU       = 1'b0;
  localparam logic [0:0] ARB_DMA_FORCE = 1'b1;
  localparam logic [3:0] LIMIT         = 4'(STARVE_LIMIT);

  logic [0:0] state, state_next;
  logic [3:0] starve_cnt, starve_next;
  logic       rd_pending, rd_owner_dma;
  logic       cpu_grant, dma_grant;
  logic       ram_en;
  logic [31:0] ram_addr, ram_wdata;
  logic [3:0]  ram_wen;

  // Grants are gated by reset so they drop the instant reset is asserted.
  always_comb begin
    // NOTE: every combinational output gets a default first, so no path can infer a latch.
    cpu_grant = 1'b0;
    dma_grant = 1'b0;
    if (resetn) begin
      if (state == ARB_CPU) begin
        cpu_grant = bus.cpu_req;
        dma_grant = bus.dma_req & ~bus.cpu_req;
      end else begin
        dma_grant = bus.dma_req;
      end
    end
  end

  always_comb begin
    ram_en    = cpu_grant | dma_grant;
    ram_addr  = '0;
    ram_wdata = '0;
    ram_wen   = '0;
    if (cpu_grant) begin
      ram_addr  = bus.cpu_addr;
      ram_wdata = bus.cpu_wdata;
      ram_wen   = bus.cpu_wen;
    end else if (dma_grant) begin
      ram_addr  = bus.dma_addr;
      ram_wdata = bus.dma_wdata;
      ram_wen   = bus.dma_wen;
    end
  end

  always_comb begin
    starve_next = '0;
    if (bus.dma_req && !dma_grant)
      starve_next = (starve_cnt >= LIMIT) ? LIMIT : starve_cnt + 4'd1;
    // The forced slot lasts one cycle and then unconditionally hands back to the CPU.
    state_next = ARB_CPU;
    if (state == ARB_CPU && starve_next == LIMIT)
      state_next = ARB_DMA_FORCE;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state        <= ARB_CPU;
      starve_cnt   <= '0;
      rd_pending   <= 1'b0;
      rd_owner_dma <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
      state        <= state_next;
      starve_cnt   <= starve_next;
      rd_pending   <= ram_en && (ram_wen == 4'b0000);
      rd_owner_dma <= dma_grant;
    end
  end

`ifdef DRAM_ARB_PERF_EN
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      perf_conflict_cnt  <= '0;
      perf_cpu_stall_cnt <= '0;
    end else begin
      if (bus.cpu_req && bus.dma_req)
        perf_conflict_cnt <= perf_conflict_cnt + 32'd1;
      if (bus.cpu_req && !cpu_grant)
        perf_cpu_stall_cnt <= perf_cpu_stall_cnt + 32'd1;
    end
  end
`endif

  assign bus.cpu_grant  = cpu_grant;
  assign bus.dma_grant  = dma_grant;
  assign bus.ram_en     = ram_en;
  assign bus.ram_addr   = ram_addr;
  assign bus.ram_wdata  = ram_wdata;
  assign bus.ram_wen    = ram_wen;
  assign bus.cpu_rvalid = rd_pending & ~rd_owner_dma;
  assign bus.dma_rvalid = rd_pending &  rd_owner_dma;
  assign bus.cpu_rdata  = bus.ram_rdata;
  assign bus.dma_rdata  = bus.ram_rdata;

  one_grant: assert property (@(posedge clk) disable iff (!resetn) !(cpu_grant && dma_grant));

endmodule
